bsg_negedge_capture_fifo: RTL
=============================

// Module: bsg_negedge_capture_fifo
// PURPOSE
//  Receiving end of a negedge-launched datapath. Upstream words are launched from falling-edge
//  flops (half-cycle paths); this block captures them on the rising edge of the same clock.
//  Words are held in a small valid/ready FIFO and presented downstream with a valid/yumi handshake.
//  Sits between negedge register stages and posedge consumers in the same clock domain.
// PARAMETERS
//  width_p  16  data word width in bits
//  els_p    2   FIFO depth; power of two, >= 2
// PORTS
//  clk_i        in   1        clock; all state updates on posedge
//  reset_n_i    in   1        asynchronous, active-low reset
//  v_i          in   1        upstream word valid (negedge-launched)
//  data_i       in   width_p  upstream word (negedge-launched)
//  ready_o      out  1        FIFO can accept a word this cycle
//  v_o          out  1        head word valid
//  data_o       out  width_p  head word
//  yumi_i       in   1        consumer takes head; legal only when v_o=1
//  overflow_o   out  1        sticky: v_i asserted while ready_o=0
//  parity_i     in   1        [PARITY_EN only] even parity over data_i
//  parity_err_o out  1        [PARITY_EN only] sticky parity mismatch
// BEHAVIOUR
//  - Reset (reset_n_i=0, async): count=0, rd/wr ptr=0, v_o=0, ready_o=1, overflow_o=0,
//    parity_err_o=0; data_o=0. Reset mid-transfer discards all held words immediately.
//  - ready_o = (count != els_p); combinational from registered count only, never from v_i/yumi_i.
//  - Enqueue when v_i & ready_o: data_i written at wr_ptr on posedge, wr_ptr increments.
//  - Dequeue when yumi_i: rd_ptr increments; data_o = mem[rd_ptr], v_o = (count != 0).
//  - Latency: word enqueued at posedge N is visible on v_o/data_o after posedge N (1 cycle);
//    no combinational fall-through from data_i to data_o.
//  - Simultaneous enq+deq: count unchanged; legal at any nonzero count below full.
//  - Full: ready_o=0; no enqueue even if yumi_i same cycle (no bypass).
//  - v_i while !ready_o: word dropped, overflow_o set, holds until reset.
//  - yumi_i while v_o=0: protocol error; ignored (no pointer/count change); assertion fires in sim.
//  - Pointers are $clog2(els_p) bits, wrap naturally at els_p; count is $clog2(els_p+1) bits.
// CONFIGURATION
//  - Macro BSG_NEGEDGE_CAPTURE_PARITY_EN:
//    defined: ports parity_i and parity_err_o exist; on each accepted enqueue, if
//      ^{data_i,parity_i} != 0, parity_err_o sets (sticky); word is still enqueued unchanged.
//    undefined: ports absent; no parity logic; all other behaviour identical.
// STRUCTURE
//  - Package bsg_negedge_capture_pkg: ptr/count width functions, status struct
//    {overflow, parity_err}, localparam default width/depth.
//  - Sub-module bsg_negedge_capture_mem: els_p x width_p posedge write, async read array,
//    no reset on storage. Top holds pointers, count, flags, handshake logic.
// TESTING
//  1 Reset: assert reset_n_i=0 mid-cycle with 2 words held -> v_o=0, ready_o=1, flags=0 at once.
//  2 Single word: v_i=1, data_i=16'hA5A5 one cycle -> next cycle v_o=1, data_o=16'hA5A5;
//    yumi_i=1 -> v_o=0 following cycle.
//  3 Fill: enqueue 16'h0001,16'h0002 with yumi_i=0 -> ready_o=0; third v_i=1 with 16'h0003
//    -> overflow_o=1, drains 0001 then 0002 only.
//  4 Streaming: v_i=1 and yumi_i=1 every cycle for 20 words 0..19 -> output order 0..19,
//    count stays 1, pointers wrap several times, overflow_o=0.
//  5 Full + yumi: full, yumi_i=1 and v_i=1 same cycle -> head dequeued, new word dropped,
//    overflow_o=1, count=1.
//  6 PARITY_EN: data_i=16'h0001, parity_i=0 -> parity_err_o=1, word still delivered;
//    build without macro -> ports absent, tests 1-5 pass unchanged.

Source files
------------

// File: rtl/bsg_negedge_capture_pkg.sv
// bsg_negedge_capture_pkg: shared widths, status flags and defaults for the negedge capture FIFO
package bsg_negedge_capture_pkg;
  localparam int default_width_p = 16;
  localparam int default_els_p = 2;
  typedef struct packed {
    logic overflow;
    logic parity_err;
  } status_t;
  function automatic int ptr_w(input int els);
    return $clog2(els);
  endfunction
  function automatic int cnt_w(input int els);
    return $clog2(els + 1);
  endfunction
endpackage

// File: rtl/bsg_negedge_capture_mem.sv
// bsg_negedge_capture_mem: els_p x width_p storage, posedge write, async read, no reset
module bsg_negedge_capture_mem
  import bsg_negedge_capture_pkg::*;
#(
  parameter int width_p = default_width_p,
  parameter int els_p = default_els_p
) (
  input  logic                      clk_i,
  input  logic                      w_v_i,
  input  logic [ptr_w(els_p)-1:0]   w_addr_i,
  input  logic [width_p-1:0]        w_data_i,
  input  logic [ptr_w(els_p)-1:0]   r_addr_i,
  output logic [width_p-1:0]        r_data_o
);
  logic [width_p-1:0] mem_q [els_p];
  // capture the negedge-launched word on the rising edge
  always_ff @(posedge clk_i)
    if (w_v_i) mem_q[w_addr_i] <= w_data_i;
  assign r_data_o = mem_q[r_addr_i];
endmodule

// File: rtl/bsg_negedge_capture_fifo.sv
// bsg_negedge_capture_fifo: posedge capture FIFO for negedge-launched words; optional parity via BSG_NEGEDGE_CAPTURE_PARITY_EN
module bsg_negedge_capture_fifo
  import bsg_negedge_capture_pkg::*;
#(
  parameter int width_p = default_width_p,
  parameter int els_p = default_els_p
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
`ifdef BSG_NEGEDGE_CAPTURE_PARITY_EN
  input  logic               parity_i,
  output logic               parity_err_o,
`endif
  output logic               overflow_o
);
  localparam int pw = ptr_w(els_p);
  localparam int cw = cnt_w(els_p);
  logic [pw-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cw-1:0] count_q, count_d;
  status_t status_q, status_d;
  logic [width_p-1:0] rd_data;
  logic enq, deq, par_bad;
  assign ready_o = count_q != cw'(els_p);
  assign v_o = count_q != '0;
  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;
  assign data_o = v_o ? rd_data : '0;
  assign overflow_o = status_q.overflow;
`ifdef BSG_NEGEDGE_CAPTURE_PARITY_EN
  assign par_bad = ^{data_i, parity_i};
  assign parity_err_o = status_q.parity_err;
`else
  logic unused_parity_err;
  assign par_bad = 1'b0;
  assign unused_parity_err = status_q.parity_err;
`endif
  // next pointers, occupancy and sticky flags; full blocks enqueue even when dequeuing
  always_comb begin
    wr_ptr_d = wr_ptr_q + pw'(enq);
    rd_ptr_d = rd_ptr_q + pw'(deq);
    count_d = count_q + cw'(enq) - cw'(deq);
    status_d.overflow = status_q.overflow | (v_i & ~ready_o);
    status_d.parity_err = status_q.parity_err | (enq & par_bad);
  end
  // state registers; reset drops all held words immediately
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      status_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      status_q <= status_d;
    end
  bsg_negedge_capture_mem #(.width_p(width_p), .els_p(els_p)) mem (
    .clk_i(clk_i),
    .w_v_i(enq),
    .w_addr_i(wr_ptr_q),
    .w_data_i(data_i),
    .r_addr_i(rd_ptr_q),
    .r_data_o(rd_data)
  );
  yumi_without_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
endmodule
